// File: rtl/mac_rx_pkg.sv
// Shared receive-path definitions: symbol geometry, block type encodings
// and the block assembler FSM state type.
package mac_rx_pkg;

  localparam int SYMBOL_WIDTH    = 8;
  localparam int BLOCK_SYMBOLS   = 16;
  localparam int LOW_GEN_SYMBOLS = 4;

  localparam logic DATA_BLK = 1'b0;
  localparam logic OS_BLK   = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/rx_block_assembler.sv
// Packs elastic-buffer symbols into complete blocks for the descrambler /
// deskew path: 16 symbols in 128b/130b mode, 4 symbols in Gen1/2 mode.
// Resynchronises on a block-type change or mode change inside a block.
//
// Ports:
//   local_clk      block clock (elastic buffer read side)
//   local_rst      asynchronous reset, active-low
//   LTSSM_rst      synchronous clear, active-high, highest priority
//   higher_gen_en  1 = 128b/130b (16 symbols), 0 = Gen1/2 (4 symbols)
//   symbol_in      incoming symbol, qualified by valid_in
//   block_type_in  0 = data, 1 = ordered set
//   valid_in       symbol qualifier
//   block_data     assembled block, symbol k at [8k+7:8k]
//   block_type_out block type of block_data
//   block_valid    one-cycle pulse, block_data updated
//   sync_err       one-cycle pulse, partial block discarded
module rx_block_assembler #(
  parameter int SYMBOL_WIDTH    = mac_rx_pkg::SYMBOL_WIDTH,
  parameter int BLOCK_SYMBOLS   = mac_rx_pkg::BLOCK_SYMBOLS,
  parameter int LOW_GEN_SYMBOLS = mac_rx_pkg::LOW_GEN_SYMBOLS,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                                  local_clk,
  input  logic                                  local_rst,
  input  logic                                  LTSSM_rst,
  input  logic                                  higher_gen_en,
  input  logic [SYMBOL_WIDTH-1:0]               symbol_in,
  input  logic                                  block_type_in,
  input  logic                                  valid_in,
  output logic [SYMBOL_WIDTH*BLOCK_SYMBOLS-1:0] block_data,
  output logic                                  block_type_out,
  output logic                                  block_valid,
  output logic                                  sync_err
);
  import mac_rx_pkg::*;

  state_e                                state_q;
  logic [CNT_WIDTH-1:0]                  idx_q;
  logic                                  cur_type_q;
  logic                                  mode_q;
  logic [SYMBOL_WIDTH*BLOCK_SYMBOLS-1:0] sym_q;

  logic [CNT_WIDTH-1:0]                  last_idx;
  logic                                  mode_change;
  logic                                  type_break;
  logic                                  complete;
  logic [SYMBOL_WIDTH*BLOCK_SYMBOLS-1:0] assembled;

  always_comb begin
    last_idx    = higher_gen_en ? CNT_WIDTH'(BLOCK_SYMBOLS - 1)
                                : CNT_WIDTH'(LOW_GEN_SYMBOLS - 1);
    // mode_q remembers the mode the current block was started in
    mode_change = (state_q == FILL) && (higher_gen_en != mode_q);
    type_break  = (state_q == FILL) && !mode_change && valid_in &&
                  (block_type_in != cur_type_q);
    complete    = (state_q == FILL) && !mode_change && valid_in &&
                  !type_break && (idx_q == last_idx);

    // The final symbol goes straight into the output, bypassing sym_q;
    // symbols beyond the active block length read as zero.
    assembled = '0;
    for (int unsigned k = 0; k < BLOCK_SYMBOLS; k++) begin
      if (k <= 32'(last_idx)) begin
        assembled[k*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
          (k == 32'(idx_q)) ? symbol_in : sym_q[k*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

  always_ff @(posedge local_clk or negedge local_rst) begin
    if (!local_rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cur_type_q     <= DATA_BLK;
      mode_q         <= 1'b0;
      sym_q          <= '0;
      block_data     <= '0;
      block_type_out <= DATA_BLK;
      block_valid    <= 1'b0;
      sync_err       <= 1'b0;
    end else begin
      block_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (LTSSM_rst) begin
        state_q <= IDLE;
        idx_q   <= '0;
        sym_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (valid_in) begin
              sym_q[0 +: SYMBOL_WIDTH] <= symbol_in;
              cur_type_q               <= block_type_in;
              mode_q                   <= higher_gen_en;
              idx_q                    <= CNT_WIDTH'(1);
              state_q                  <= FILL;
            end
          end
          FILL: begin
            if (mode_change) begin
              sync_err <= 1'b1;
              idx_q    <= '0;
              state_q  <= IDLE;
            end else if (valid_in) begin
              if (type_break) begin
                // offending symbol restarts the block at index 0
                sync_err                 <= 1'b1;
                sym_q[0 +: SYMBOL_WIDTH] <= symbol_in;
                cur_type_q               <= block_type_in;
                idx_q                    <= CNT_WIDTH'(1);
              end else if (complete) begin
                block_data     <= assembled;
                block_type_out <= cur_type_q;
                block_valid    <= 1'b1;
                idx_q          <= '0;
                state_q        <= IDLE;
              end else begin
                sym_q[int'(idx_q)*SYMBOL_WIDTH +: SYMBOL_WIDTH] <= symbol_in;
                idx_q <= idx_q + CNT_WIDTH'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_block_assembler.sv
// Directed, table-driven bench for rx_block_assembler.
module tb_rx_block_assembler;
  import mac_rx_pkg::*;

  localparam int W = 8 * 16;

  logic         local_clk = 1'b0;
  logic         local_rst;
  logic         LTSSM_rst;
  logic         higher_gen_en;
  logic [7:0]   symbol_in;
  logic         block_type_in;
  logic         valid_in;
  logic [W-1:0] block_data;
  logic         block_type_out;
  logic         block_valid;
  logic         sync_err;

  typedef struct {
    logic         gen;
    logic         ltssm;
    logic         valid;
    logic         typ;
    logic [7:0]   sym;
    logic         exp_bv;
    logic         exp_se;
    logic [W-1:0] exp_data;
    logic         exp_type;
    string        name;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] held_data;
  logic         held_type;
  int           n_checks = 0;
  int           n_fail   = 0;

  rx_block_assembler #(
    .SYMBOL_WIDTH   (8),
    .BLOCK_SYMBOLS  (16),
    .LOW_GEN_SYMBOLS(4),
    .CNT_WIDTH      (4)
  ) dut (
    .local_clk     (local_clk),
    .local_rst     (local_rst),
    .LTSSM_rst     (LTSSM_rst),
    .higher_gen_en (higher_gen_en),
    .symbol_in     (symbol_in),
    .block_type_in (block_type_in),
    .valid_in      (valid_in),
    .block_data    (block_data),
    .block_type_out(block_type_out),
    .block_valid   (block_valid),
    .sync_err      (sync_err)
  );

  always #5 local_clk = ~local_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic set_block(input logic [W-1:0] d, input logic t);
    held_data = d;
    held_type = t;
  endtask

  task automatic add(input logic gen, input logic ltssm, input logic valid, input logic typ,
                     input logic [7:0] sym, input logic bv, input logic se, input string name);
    vec_t v;
    v.gen = gen; v.ltssm = ltssm; v.valid = valid; v.typ = typ; v.sym = sym;
    v.exp_bv = bv; v.exp_se = se; v.exp_data = held_data; v.exp_type = held_type;
    v.name = name;
    tbl.push_back(v);
  endtask

  // Each row: drive inputs, take one edge, sample 1 time unit later.
  task automatic run_table();
    foreach (tbl[i]) begin
      higher_gen_en = tbl[i].gen;
      LTSSM_rst     = tbl[i].ltssm;
      valid_in      = tbl[i].valid;
      block_type_in = tbl[i].typ;
      symbol_in     = tbl[i].sym;
      @(posedge local_clk);
      #1;
      check({tbl[i].name, "_bv"},   W'(block_valid),    W'(tbl[i].exp_bv));
      check({tbl[i].name, "_se"},   W'(sync_err),       W'(tbl[i].exp_se));
      check({tbl[i].name, "_data"}, block_data,         tbl[i].exp_data);
      check({tbl[i].name, "_type"}, W'(block_type_out), W'(tbl[i].exp_type));
    end
    tbl.delete();
    valid_in  = 1'b0;
    LTSSM_rst = 1'b0;
  endtask

  initial begin
    local_rst = 1'b0; LTSSM_rst = 1'b0; higher_gen_en = 1'b1;
    symbol_in = '0; block_type_in = 1'b0; valid_in = 1'b0;
    set_block('0, 1'b0);

    repeat (2) @(posedge local_clk);
    #1;
    check("rst_data", block_data, '0);
    check("rst_type", W'(block_type_out), '0);
    check("rst_bv",   W'(block_valid), '0);
    check("rst_se",   W'(sync_err), '0);
    @(negedge local_clk);
    local_rst = 1'b1;

    // basic 16-symbol block
    for (int i = 0; i < 15; i++) add(1, 0, 1, DATA_BLK, 8'(i), 0, 0, "basic");
    set_block(128'h0F0E0D0C0B0A09080706050403020100, DATA_BLK);
    add(1, 0, 1, DATA_BLK, 8'h0F, 1, 0, "basic_last");
    add(1, 0, 0, DATA_BLK, 8'h00, 0, 0, "basic_after");

    // same symbols with a gap after every valid symbol
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        add(1, 0, 1, DATA_BLK, 8'(i), 1, 0, "gap_last");
      end else begin
        add(1, 0, 1, DATA_BLK, 8'(i), 0, 0, "gap_sym");
        add(1, 0, 0, DATA_BLK, 8'h00, 0, 0, "gap_idle");
      end
    end
    add(1, 0, 0, DATA_BLK, 8'h00, 0, 0, "gap_after");

    // type break: 5 data symbols then OS 0xAA + 15 x OS 0xBB
    for (int i = 0; i < 5; i++) add(1, 0, 1, DATA_BLK, 8'h50 + 8'(i), 0, 0, "brk_data");
    add(1, 0, 1, OS_BLK, 8'hAA, 0, 1, "brk_aa");
    for (int i = 0; i < 14; i++) add(1, 0, 1, OS_BLK, 8'hBB, 0, 0, "brk_bb");
    set_block({{15{8'hBB}}, 8'hAA}, OS_BLK);
    add(1, 0, 1, OS_BLK, 8'hBB, 1, 0, "brk_last");

    // Gen1/2 four-symbol word
    add(0, 0, 1, DATA_BLK, 8'h11, 0, 0, "g12");
    add(0, 0, 1, DATA_BLK, 8'h22, 0, 0, "g12");
    add(0, 0, 1, DATA_BLK, 8'h33, 0, 0, "g12");
    set_block(128'h44332211, DATA_BLK);
    add(0, 0, 1, DATA_BLK, 8'h44, 1, 0, "g12_last");

    // LTSSM clear while presenting index 9; outputs hold
    for (int i = 0; i < 9; i++) add(1, 0, 1, DATA_BLK, 8'h60 + 8'(i), 0, 0, "ltssm_pre");
    add(1, 1, 1, DATA_BLK, 8'h99, 0, 0, "ltssm_clr");
    for (int i = 0; i < 15; i++) add(1, 0, 1, DATA_BLK, 8'h20 + 8'(i), 0, 0, "ltssm_post");
    set_block(128'h2F2E2D2C2B2A29282726252423222120, DATA_BLK);
    add(1, 0, 1, DATA_BLK, 8'h2F, 1, 0, "ltssm_last");

    // mode change mid-block drops the presented symbol
    for (int i = 0; i < 3; i++) add(1, 0, 1, DATA_BLK, 8'h70 + 8'(i), 0, 0, "mode_pre");
    add(0, 0, 1, DATA_BLK, 8'h73, 0, 1, "mode_chg");
    add(0, 0, 1, DATA_BLK, 8'h01, 0, 0, "mode_post");
    add(0, 0, 1, DATA_BLK, 8'h02, 0, 0, "mode_post");
    add(0, 0, 1, DATA_BLK, 8'h03, 0, 0, "mode_post");
    set_block(128'h04030201, DATA_BLK);
    add(0, 0, 1, DATA_BLK, 8'h04, 1, 0, "mode_last");

    // type break on the would-be last symbol: break wins, no block
    for (int i = 0; i < 3; i++) add(0, 0, 1, DATA_BLK, 8'h80 + 8'(i), 0, 0, "brk3_pre");
    add(0, 0, 1, OS_BLK, 8'hCC, 0, 1, "brk3_cc");
    add(0, 0, 1, OS_BLK, 8'hDD, 0, 0, "brk3_dd");
    add(0, 0, 1, OS_BLK, 8'hDD, 0, 0, "brk3_dd");
    set_block(128'hDDDDDDCC, OS_BLK);
    add(0, 0, 1, OS_BLK, 8'hDD, 1, 0, "brk3_last");

    // back-to-back Gen1/2 words
    add(0, 0, 1, DATA_BLK, 8'hA1, 0, 0, "b2b");
    add(0, 0, 1, DATA_BLK, 8'hA2, 0, 0, "b2b");
    add(0, 0, 1, DATA_BLK, 8'hA3, 0, 0, "b2b");
    set_block(128'hA4A3A2A1, DATA_BLK);
    add(0, 0, 1, DATA_BLK, 8'hA4, 1, 0, "b2b_first");
    add(0, 0, 1, DATA_BLK, 8'hB1, 0, 0, "b2b");
    add(0, 0, 1, DATA_BLK, 8'hB2, 0, 0, "b2b");
    add(0, 0, 1, DATA_BLK, 8'hB3, 0, 0, "b2b");
    set_block(128'hB4B3B2B1, DATA_BLK);
    add(0, 0, 1, DATA_BLK, 8'hB4, 1, 0, "b2b_second");

    run_table();

    // asynchronous reset in the middle of a 16-symbol fill
    for (int i = 0; i < 7; i++) add(1, 0, 1, DATA_BLK, 8'h40 + 8'(i), 0, 0, "arst_pre");
    run_table();
    #2;
    local_rst = 1'b0;
    #1;
    check("arst_data", block_data, '0);
    check("arst_type", W'(block_type_out), '0);
    check("arst_bv",   W'(block_valid), '0);
    check("arst_se",   W'(sync_err), '0);
    @(negedge local_clk);
    local_rst = 1'b1;

    set_block('0, DATA_BLK);
    for (int i = 0; i < 15; i++) add(1, 0, 1, DATA_BLK, 8'h30 + 8'(i), 0, 0, "arst_post");
    set_block(128'h3F3E3D3C3B3A39383736353433323130, DATA_BLK);
    add(1, 0, 1, DATA_BLK, 8'h3F, 1, 0, "arst_last");
    add(1, 0, 0, DATA_BLK, 8'h00, 0, 0, "arst_after");
    run_table();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
